// File: rtl/clock_control_if.sv
// Panel-side signals of the CPU clock controller: raw key/button/halt in; enable, mode and step count out.
interface clock_control_if #(
  parameter int CNT_W = 8
);
  logic             key_i;
  logic             btn_i;
  logic             halt_i;
  logic             clk_en_o;
  logic             mode_o;
  logic [CNT_W-1:0] step_count_o;

  modport master (
    output key_i, btn_i, halt_i,
    input  clk_en_o, mode_o, step_count_o
  );

  modport slave (
    input  key_i, btn_i, halt_i,
    output clk_en_o, mode_o, step_count_o
  );
endinterface

// File: rtl/clock_control.sv
// CPU clock-enable generator: 2-flop sync + debounce on key/button, auto divider or manual single-step.
// Debounced level follows a clean raw edge 2+DEBOUNCE_CYCLES cycles later; a manual pulse follows one cycle after that.
module clock_control #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_DIV        = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  clock_control_if.slave   io
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIVW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(AUTO_DIV - 1);

  // Bit 0 carries the mode key, bit 1 the step button.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_q, db_d;
  logic [1:0][DBW-1:0]  dbc_q, dbc_d;
  logic                 btn_prev_q, btn_prev_d;
  logic [DIVW-1:0]      div_q, div_d;
  logic                 clk_en_q, clk_en_d;
  logic [CNT_W-1:0]     step_q, step_d;

  logic                 mode_chg;
  logic                 btn_rise;

  always_comb begin
    sync1_d = {io.btn_i, io.key_i};
    sync2_d = sync1_q;
    db_d    = db_q;
    dbc_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  assign mode_chg   = db_d[0] != db_q[0];
  assign btn_rise   = db_q[1] & ~btn_prev_q;
  assign btn_prev_d = db_q[1];

  // Events coinciding with a mode flip are dropped; halt masks the pulse but not the divider.
  always_comb begin
    div_d    = '0;
    clk_en_d = 1'b0;
    if (!mode_chg && !db_q[0]) begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      clk_en_d = (div_q == DIV_LAST) && !io.halt_i;
    end
    if (!mode_chg && db_q[0] && btn_rise && !io.halt_i) begin
      clk_en_d = 1'b1;
    end
    step_d = step_q + CNT_W'(clk_en_q);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      dbc_q      <= '0;
      btn_prev_q <= 1'b0;
      div_q      <= '0;
      clk_en_q   <= 1'b0;
      step_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      dbc_q      <= dbc_d;
      btn_prev_q <= btn_prev_d;
      div_q      <= div_d;
      clk_en_q   <= clk_en_d;
      step_q     <= step_d;
    end
  end

  assign io.clk_en_o     = clk_en_q;
  assign io.mode_o       = db_q[0];
  assign io.step_count_o = step_q;

endmodule

// File: doc/clock_control.md
Name: clock_control

Overview:
- Front-end controller for the physical inputs that drive the 8-bit CPU top: the mode key and the step button.
- Synchronises and debounces both inputs.
- Selects auto-run or manual single-step mode.
- Issues one-cycle CPU clock-enable pulses. The CPU core advances only on cycles where clk_en_o is high.
- Also exports an 8-bit count of issued steps for LED display.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronised samples differing from the debounced level required before the debounced level flips (>=2).
AUTO_DIV, 8, clk cycles per enable pulse in auto mode (>=2).
CNT_W, 8, width of step_count_o.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
key_i  input  1  raw mode key, asynchronous to clk; debounced 1 = manual step, 0 = auto run
btn_i  input  1  raw step button, asynchronous to clk; active-high
halt_i  input  1  CPU HLT flag, synchronous to clk; high suppresses all pulses
clk_en_o  output  1  registered one-cycle CPU advance enable
mode_o  output  1  debounced key level (1 = manual)
step_count_o  output  CNT_W  number of clk_en_o pulses issued, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release):
  - clk_en_o=0, mode_o=0, step_count_o=0.
  - Synchroniser flops, debounced levels, debounce counters and divider all 0.
- Synchronisation: each raw input passes through 2 flops. The synced value lags the raw value by 2 clk edges.
- Debounce, independent per input:
  - Each cycle, if synced != debounced, increment that input's counter. Otherwise clear the counter.
  - When the counter equals DEBOUNCE_CYCLES-1 and synced still differs, flip debounced and clear the counter.
  - A clean raw edge appears on the debounced level 2+DEBOUNCE_CYCLES cycles later.
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- mode_o = debounced key, registered.
- Manual mode (mode_o=1):
  - A rising edge of debounced btn produces exactly one clk_en_o pulse on the following cycle, regardless of hold duration.
  - The falling edge produces nothing.
  - The divider is held at 0.
- Auto mode (mode_o=0):
  - The divider counts 0..AUTO_DIV-1 and wraps.
  - clk_en_o is high for the one cycle after the divider equals AUTO_DIV-1, giving a period of exactly AUTO_DIV cycles.
  - Button edges are ignored.
- Mode change: on any mode_o transition the divider clears to 0.
  - In manual to auto, the first auto pulse occurs AUTO_DIV cycles after mode_o falls.
  - A button edge coinciding with the mode_o transition is ignored.
- Halt:
  - While halt_i=1, clk_en_o is forced 0.
  - The auto divider keeps counting, and pulses that would have occurred are dropped (not queued).
  - A manual edge during halt is discarded.
- step_count_o increments by 1 on every cycle clk_en_o=1. It wraps from 2^CNT_W-1 to 0.
- Reset mid-operation (rst_i asserted at any time):
  - Immediately zeroes all state, including any in-flight pulse.
  - After release, mode_o=0 (auto) until the debounced key reaches 1.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_DIV=8, CNT_W=8):
1. Reset, key_i=0 for 100 cycles -> clk_en_o pulses every 8th cycle, one cycle wide; step_count_o=12 after 100 cycles (first pulse 8 cycles after reset release).
2. key_i rises at cycle N -> mode_o rises at N+6; no further auto pulses. btn_i high 50 cycles then low -> exactly one clk_en_o, 7 cycles after btn_i rise; step_count_o +1.
3. Manual mode, btn_i glitches high for 3 cycles, five times -> zero pulses, step_count_o unchanged.
4. Auto mode, halt_i=1 for 30 cycles -> clk_en_o=0 throughout, no catch-up burst after halt_i falls; next pulse stays aligned to the divider period.
5. rst_i asserted mid auto run with step_count_o=37 -> all outputs 0 on the same cycle; after release, count restarts from 0, mode_o=0.
6. 256 manual steps from reset -> step_count_o wraps to 0 after the 256th pulse.
